scc_mem_responder: RTL and testbench
====================================

Name: scc_mem_responder

Overview:
Memory-side responder for the SCC core's instruction and data interfaces: serves instruction fetches and data reads/writes from one word-organised internal array.
Instruction port: fixed 1-cycle latency.
Data port: configurable wait states, with valid/busy/fault status back to the core side.
Instantiated beside the SCC core in the top level; also the standard memory model in core benches.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KiB)
WAIT_STATES, 1, extra cycles between data request acceptance and response (0..15 legal)

Ports:
clk  input  1  main clock, all state on rising edge
reset  input  1  asynchronous, active-high; sets all regs to known state
in_mem_addr  input  32  byte address of instruction fetch
in_mem_en  input  1  fetch request, sampled every cycle
in_mem  output  32  fetched instruction word
in_mem_valid  output  1  in_mem holds response to previous-cycle fetch
in_mem_fault  output  1  previous-cycle fetch misaligned or out of range
data_addr  input  32  byte address of data access
data_out  input  32  write data from core
data_read  input  1  read request
data_write  input  1  write request
data_in  output  32  read data to core
data_valid  output  1  one-cycle pulse: data access complete
data_busy  output  1  data FSM not IDLE; new requests ignored
data_fault  output  1  qualifies data_valid; access faulted

Behaviour:
- Reset (async assert, any state): all outputs 0; FSM to IDLE; wait counter 0; captured request and any pending write discarded. Array contents are not cleared.
- Addressing: word index = addr[DEPTH_LOG2+1:2].
- Faulting address: addr[1:0] != 0, or any bit addr[31:DEPTH_LOG2+2] set.
- Faulting access: never writes; read data returns 0.
- Fetch path, every edge:
  - If in_mem_en=1: in_mem <= word (0 on fault); in_mem_valid <= 1; in_mem_fault <= fault.
  - Else: in_mem_valid <= 0; in_mem_fault <= 0; in_mem holds.
  - Back-to-back fetches give one response per cycle.
- Data FSM states: IDLE, WAIT, RESP.
- IDLE:
  - data_read or data_write high: capture addr, write data and op.
  - data_read and data_write both high: treated as faulting no-op.
  - Go to WAIT with counter = WAIT_STATES; if WAIT_STATES = 0, go directly to RESP.
- WAIT: counter decrements each cycle; leave for RESP on the edge where counter = 1.
- Entering RESP (single edge):
  - Write committed to array if write and not faulting.
  - Read data registered into data_in (0 on fault); data_in unchanged on writes.
  - data_fault set per captured request.
- RESP: data_valid=1 for exactly one cycle; next edge returns to IDLE with data_valid=0 and data_fault=0.
- data_busy=1 in WAIT and RESP, 0 in IDLE.
- Requests seen outside IDLE are ignored, not queued. The core holds or reissues the request after data_valid.
- Latency: data_valid rises WAIT_STATES+1 cycles after the accepting edge. A request is accepted again no earlier than the edge after RESP.
- data_in holds the last read value until the next completed read.
- Same-edge fetch and data write to the same word: fetch returns old data (read-before-write).
- Reset during WAIT/RESP: write not committed, no data_valid pulse.

Test Plan:
- Reset, then preload word 5 = 0xDEADBEEF by backdoor; fetch in_mem_addr=0x14, in_mem_en=1 -> next cycle in_mem=0xDEADBEEF, in_mem_valid=1, in_mem_fault=0.
- WAIT_STATES=1:
  - Write 0x12345678 to 0x40, then read 0x40 -> each data_valid 2 cycles after acceptance; read gives data_in=0x12345678, data_fault=0.
  - data_busy=1 for exactly 2 cycles per access.
- Misaligned read 0x42 and out-of-range write 0x1000 -> data_valid with data_fault=1; data_in=0; word at index 0 unchanged.
- data_read held high during WAIT, plus a second read to another address issued while busy -> only the first is served; the second is served only if still asserted after data_valid.
- Write 0xAAAA0000 to 0x8 on the same edge as fetch of 0x8 (old value 0x11) -> in_mem=0x11; next fetch returns 0xAAAA0000.
- Reset asserted mid-WAIT of a write of 0xFFFF to 0x20 -> outputs 0 immediately, no data_valid, word 8 keeps its prior value.
- WAIT_STATES=0 -> data_valid the cycle after acceptance; back-to-back reads 0x0, 0x4 complete on alternating cycles.

Source files
------------

// File: rtl/scc_mem_responder.sv
// Memory responder for the SCC core: one word array behind a fixed-latency
// instruction port and a wait-state data port with valid/busy/fault status.
module scc_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_mem_addr,
  input  logic        in_mem_en,
  output logic [31:0] in_mem,
  output logic        in_mem_valid,
  output logic        in_mem_fault,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_valid,
  output logic        data_busy,
  output logic        data_fault
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|a[31:DEPTH_LOG2+2]);
  endfunction

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_rd;
  logic        cap_wr;

  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic                  cur_rd;
  logic                  cur_wr;
  logic                  cur_fault;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  enter_resp;

  logic                  fetch_fault;
  logic [DEPTH_LOG2-1:0] fetch_idx;

  // In IDLE the live request is used so a zero-wait access completes on its accepting edge.
  always_comb begin
    cur_addr   = cap_addr;
    cur_wdata  = cap_wdata;
    cur_rd     = cap_rd;
    cur_wr     = cap_wr;
    enter_resp = 1'b0;
    if (state == S_IDLE) begin
      cur_addr   = data_addr;
      cur_wdata  = data_out;
      cur_rd     = data_read;
      cur_wr     = data_write;
      enter_resp = (data_read || data_write) && (WAIT_STATES == 0);
    end else if (state == S_WAIT) begin
      enter_resp = (cnt == 4'd1);
    end
    cur_fault = addr_fault(cur_addr) || (cur_rd && cur_wr);
    cur_idx   = cur_addr[DEPTH_LOG2+1:2];
  end

  assign fetch_fault = addr_fault(in_mem_addr);
  assign fetch_idx   = in_mem_addr[DEPTH_LOG2+1:2];

  // Both reads of mem sample the pre-edge contents, so a same-edge fetch sees the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_mem       <= '0;
      in_mem_valid <= 1'b0;
      in_mem_fault <= 1'b0;
    end else if (in_mem_en) begin
      in_mem       <= fetch_fault ? '0 : mem[fetch_idx];
      in_mem_valid <= 1'b1;
      in_mem_fault <= fetch_fault;
    end else begin
      in_mem_valid <= 1'b0;
      in_mem_fault <= 1'b0;
    end
  end

  // The array lives in the reset process only so a write can never commit while reset is high;
  // the reset branch deliberately leaves its contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_rd     <= 1'b0;
      cap_wr     <= 1'b0;
      data_in    <= '0;
      data_valid <= 1'b0;
      data_busy  <= 1'b0;
      data_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_read || data_write) begin
            cap_addr  <= data_addr;
            cap_wdata <= data_out;
            cap_rd    <= data_read;
            cap_wr    <= data_write;
            data_busy <= 1'b1;
            if (WAIT_STATES != 0) begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd1) cnt <= cnt - 4'd1;
        end
        S_RESP: begin
          state      <= S_IDLE;
          data_valid <= 1'b0;
          data_fault <= 1'b0;
          data_busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        if (cur_wr && !cur_fault) mem[cur_idx] <= cur_wdata;
        if (cur_rd) data_in <= cur_fault ? '0 : mem[cur_idx];
        data_fault <= cur_fault;
        data_valid <= 1'b1;
        data_busy  <= 1'b1;
        state      <= S_RESP;
        cnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scc_mem_responder.sv
// Directed bench for scc_mem_responder: one instance with one wait state, one with none.
module tb_scc_mem_responder;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] in_mem_addr;
  logic        in_mem_en;
  logic [31:0] in_mem;
  logic        in_mem_valid;
  logic        in_mem_fault;

  logic [31:0] f0_addr;
  logic        f0_en;
  logic [31:0] f0_mem;
  logic        f0_valid;
  logic        f0_fault;

  // index 1: WAIT_STATES=1 instance, index 0: WAIT_STATES=0 instance
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic        d_rd    [2];
  logic        d_wr    [2];
  logic        d_valid [2];
  logic        d_busy  [2];
  logic        d_fault [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scc_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en),
    .in_mem(in_mem), .in_mem_valid(in_mem_valid), .in_mem_fault(in_mem_fault),
    .data_addr(d_addr[1]), .data_out(d_wdata[1]),
    .data_read(d_rd[1]), .data_write(d_wr[1]),
    .data_in(d_rdata[1]), .data_valid(d_valid[1]),
    .data_busy(d_busy[1]), .data_fault(d_fault[1])
  );

  scc_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_mem_addr(f0_addr), .in_mem_en(f0_en),
    .in_mem(f0_mem), .in_mem_valid(f0_valid), .in_mem_fault(f0_fault),
    .data_addr(d_addr[0]), .data_out(d_wdata[0]),
    .data_read(d_rd[0]), .data_write(d_wr[0]),
    .data_in(d_rdata[0]), .data_valid(d_valid[0]),
    .data_busy(d_busy[0]), .data_fault(d_fault[0])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge, then waits (bounded) for data_valid.
  task automatic do_access(input int sel, input logic [31:0] a, input logic [31:0] d,
                           input logic r, input logic w,
                           output int lat, output int busy_n,
                           output logic flt, output logic [31:0] rdata);
    d_addr[sel] = a; d_wdata[sel] = d; d_rd[sel] = r; d_wr[sel] = w;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (d_busy[sel]) busy_n++;
      d_rd[sel] = 1'b0; d_wr[sel] = 1'b0;
    end while (!d_valid[sel] && lat < 20);
    flt   = d_fault[sel];
    rdata = d_rdata[sel];
    @(negedge clk);
    if (d_busy[sel]) busy_n++;
    check("valid_one_cycle", {31'd0, d_valid[sel]}, 32'd0);
  endtask

  int          lat, busy_n, seen;
  logic        flt;
  logic [31:0] rdata;

  initial begin
    reset = 1'b1;
    in_mem_addr = '0; in_mem_en = 1'b0; f0_addr = '0; f0_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_addr[i] = '0; d_wdata[i] = '0; d_rd[i] = 1'b0; d_wr[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_in_mem_valid", {31'd0, in_mem_valid}, 32'd0);
    check("rst_in_mem", in_mem, 32'd0);
    check("rst_status", {28'd0, d_valid[1], d_busy[1], d_fault[1], in_mem_fault}, 32'd0);
    check("rst_data_in", d_rdata[1], 32'd0);
    reset = 1'b0;

    dut1.mem[0]  = 32'hCAFE0000;
    dut1.mem[2]  = 32'h00000011;
    dut1.mem[5]  = 32'hDEADBEEF;
    dut1.mem[8]  = 32'h00005555;
    dut1.mem[17] = 32'h44444444;
    dut0.mem[1]  = 32'h000000A1;
    dut0.mem[2]  = 32'h000000A2;
    dut0.mem[0]  = 32'h000000A0;

    // instruction fetch
    in_mem_addr = 32'h14; in_mem_en = 1'b1;
    @(negedge clk);
    check("fetch_word", in_mem, 32'hDEADBEEF);
    check("fetch_valid", {31'd0, in_mem_valid}, 32'd1);
    check("fetch_fault", {31'd0, in_mem_fault}, 32'd0);
    in_mem_addr = 32'h15;
    @(negedge clk);
    check("fetch_mis_word", in_mem, 32'd0);
    check("fetch_mis_fault", {31'd0, in_mem_fault}, 32'd1);
    in_mem_en = 1'b0; in_mem_addr = 32'h14;
    @(negedge clk);
    check("fetch_idle_valid", {31'd0, in_mem_valid}, 32'd0);
    check("fetch_idle_fault", {31'd0, in_mem_fault}, 32'd0);

    // write then read back with one wait state
    do_access(1, 32'h40, 32'h12345678, 1'b0, 1'b1, lat, busy_n, flt, rdata);
    check("wr_latency", lat, 32'd2);
    check("wr_busy_cycles", busy_n, 32'd2);
    check("wr_fault", {31'd0, flt}, 32'd0);
    do_access(1, 32'h40, 32'h0, 1'b1, 1'b0, lat, busy_n, flt, rdata);
    check("rd_latency", lat, 32'd2);
    check("rd_busy_cycles", busy_n, 32'd2);
    check("rd_data", rdata, 32'h12345678);
    check("rd_fault", {31'd0, flt}, 32'd0);

    // faulting accesses
    do_access(1, 32'h42, 32'h0, 1'b1, 1'b0, lat, busy_n, flt, rdata);
    check("mis_rd_fault", {31'd0, flt}, 32'd1);
    check("mis_rd_data", rdata, 32'd0);
    do_access(1, 32'h1000, 32'h77, 1'b0, 1'b1, lat, busy_n, flt, rdata);
    check("oor_wr_fault", {31'd0, flt}, 32'd1);
    check("oor_wr_data_in_held", rdata, 32'd0);
    do_access(1, 32'h40, 32'h0, 1'b1, 1'b1, lat, busy_n, flt, rdata);
    check("rdwr_both_fault", {31'd0, flt}, 32'd1);
    do_access(1, 32'h0, 32'h0, 1'b1, 1'b0, lat, busy_n, flt, rdata);
    check("word0_unchanged", rdata, 32'hCAFE0000);
    check("word0_fault", {31'd0, flt}, 32'd0);

    // held read plus a second request issued while busy
    d_addr[1] = 32'h40; d_rd[1] = 1'b1;
    @(negedge clk);
    check("held_busy", {31'd0, d_busy[1]}, 32'd1);
    check("held_valid_early", {31'd0, d_valid[1]}, 32'd0);
    d_addr[1] = 32'h44;
    @(negedge clk);
    check("held_first_valid", {31'd0, d_valid[1]}, 32'd1);
    check("held_first_data", d_rdata[1], 32'h12345678);
    @(negedge clk);
    check("held_gap_valid", {31'd0, d_valid[1]}, 32'd0);
    check("held_gap_busy", {31'd0, d_busy[1]}, 32'd0);
    @(negedge clk);
    check("held_second_busy", {31'd0, d_busy[1]}, 32'd1);
    @(negedge clk);
    check("held_second_valid", {31'd0, d_valid[1]}, 32'd1);
    check("held_second_data", d_rdata[1], 32'h44444444);
    d_rd[1] = 1'b0;
    @(negedge clk);

    // fetch of a word on the edge its write commits
    d_addr[1] = 32'h8; d_wdata[1] = 32'hAAAA0000; d_wr[1] = 1'b1;
    @(negedge clk);
    d_wr[1] = 1'b0; in_mem_addr = 32'h8; in_mem_en = 1'b1;
    @(negedge clk);
    check("rbw_wr_valid", {31'd0, d_valid[1]}, 32'd1);
    check("rbw_old_word", in_mem, 32'h00000011);
    @(negedge clk);
    check("rbw_new_word", in_mem, 32'hAAAA0000);
    in_mem_en = 1'b0;
    @(negedge clk);

    // reset in the middle of a write's wait state
    d_addr[1] = 32'h20; d_wdata[1] = 32'h0000FFFF; d_wr[1] = 1'b1;
    @(negedge clk);
    check("rstw_busy_before", {31'd0, d_busy[1]}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstw_busy", {31'd0, d_busy[1]}, 32'd0);
    check("rstw_data_in", d_rdata[1], 32'd0);
    check("rstw_in_mem", in_mem, 32'd0);
    @(negedge clk);
    reset = 1'b0; d_wr[1] = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_valid[1]) seen++;
    end
    check("rstw_no_valid", seen, 32'd0);
    do_access(1, 32'h20, 32'h0, 1'b1, 1'b0, lat, busy_n, flt, rdata);
    check("rstw_word_kept", rdata, 32'h00005555);

    // zero wait states
    do_access(0, 32'h0, 32'h0, 1'b1, 1'b0, lat, busy_n, flt, rdata);
    check("ws0_latency", lat, 32'd1);
    check("ws0_busy_cycles", busy_n, 32'd1);
    check("ws0_data", rdata, 32'h000000A0);
    d_addr[0] = 32'h4; d_rd[0] = 1'b1;
    @(negedge clk);
    check("ws0_b2b_valid1", {31'd0, d_valid[0]}, 32'd1);
    check("ws0_b2b_data1", d_rdata[0], 32'h000000A1);
    d_addr[0] = 32'h8;
    @(negedge clk);
    check("ws0_b2b_gap", {31'd0, d_valid[0]}, 32'd0);
    @(negedge clk);
    check("ws0_b2b_valid2", {31'd0, d_valid[0]}, 32'd1);
    check("ws0_b2b_data2", d_rdata[0], 32'h000000A2);
    d_rd[0] = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
